// File: rtl/compare_arbiter.sv
// Two-port arbiter in front of one shared 4-bit unsigned comparator.
// Define COMPARE_ARBITER_RR_EN for round-robin tie-breaking; the default is fixed priority (port 0).
module compare_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       less,
    output logic       greater,
    output logic       equal,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StCmp, StResp} state_e;

    state_e     state_q, state_d;
    logic       winner_q, winner_d;  // 0: port 0 owns the comparator, 1: port 1
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] op_b_q, op_b_d;
    logic       less_q, greater_q, equal_q;
    logic       cmp_lt, cmp_gt;
    logic       tie_pick;

`ifdef COMPARE_ARBITER_RR_EN
    logic last_q;  // 1: port 1 was served last

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (state_q == StIdle && (req0 || req1)) begin
            last_q <= winner_d;
        end
    end

    assign tie_pick = ~last_q;
`else
    assign tie_pick = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            winner_q <= 1'b0;
            op_a_q   <= 4'd0;
            op_b_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    winner_d = (req0 && req1) ? tie_pick : req1;
                    op_a_d   = winner_d ? a1 : a0;
                    op_b_d   = winner_d ? b1 : b0;
                    state_d  = StCmp;
                end
            end
            StCmp:   state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The single shared comparator, fed only from the latched operands
    assign cmp_lt = op_a_q < op_b_q;
    assign cmp_gt = op_b_q < op_a_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            less_q    <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
        end else if (state_q == StCmp) begin
            less_q    <= cmp_lt;
            greater_q <= cmp_gt;
            equal_q   <= ~(cmp_lt | cmp_gt);
        end
    end

    // Output logic
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        busy    = (state_q != StIdle);
        less    = less_q;
        greater = greater_q;
        equal   = equal_q;
        unique case (state_q)
            StIdle: ;
            StCmp: begin
                gnt0 = ~winner_q;
                gnt1 = winner_q;
            end
            StResp: begin
                gnt0  = ~winner_q;
                gnt1  = winner_q;
                done0 = ~winner_q;
                done1 = winner_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_compare_arbiter.sv
// Self-checking bench for compare_arbiter: transaction-timeline model plus directed vectors.
// Works with or without COMPARE_ARBITER_RR_EN defined.
module tb_compare_arbiter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0  = 1'b0;
    logic       req1  = 1'b0;
    logic [3:0] a0    = 4'd0;
    logic [3:0] b0    = 4'd0;
    logic [3:0] a1    = 4'd0;
    logic [3:0] b1    = 4'd0;
    logic       gnt0, gnt1, done0, done1, less, greater, equal, busy;
    logic [7:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    compare_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .less    (less),
        .greater (greater),
        .equal   (equal),
        .busy    (busy)
    );

    assign obs = {gnt0, gnt1, done0, done1, less, greater, equal, busy};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b (gnt0 gnt1 done0 done1 lt gt eq busy)",
                     name, $time, act, exp);
        end
    endtask

    // Model: a transaction is a record of (accepting edge, winner, result); outputs follow
    // from how many edges have passed since that acceptance.
    int         m        = 0;
    int         acc_edge = 0;
    bit         acc_valid = 1'b0;
    bit         acc_w    = 1'b0;
    bit         last     = 1'b1;
    logic [2:0] pend     = 3'b000;
    logic [2:0] res      = 3'b000;

    function automatic logic [2:0] relate(input logic [3:0] a, input logic [3:0] b);
        int diff;
        diff = int'(a) - int'(b);
        return {diff < 0, diff > 0, diff == 0};
    endfunction

    function automatic bit pick(input bit r0, input bit r1, input bit l);
        if (r0 && r1) begin
`ifdef COMPARE_ARBITER_RR_EN
            return !l;
`else
            return 1'b0;
`endif
        end
        return r1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_valid <= 1'b0;
            last      <= 1'b1;
            res       <= 3'b000;
        end else begin
            m <= m + 1;
            if (acc_valid && m == acc_edge) res <= pend;
            if ((!acc_valid || m + 1 >= acc_edge + 3) && (req0 || req1)) begin
                acc_valid <= 1'b1;
                acc_edge  <= m + 1;
                acc_w     <= pick(req0, req1, last);
                last      <= pick(req0, req1, last);
                pend      <= pick(req0, req1, last) ? relate(a1, b1) : relate(a0, b0);
            end
        end
    end

    function automatic logic [7:0] model_vec();
        int d;
        bit act, dn;
        d   = m - acc_edge;
        act = acc_valid && d < 2;
        dn  = acc_valid && d == 1;
        return {act && !acc_w, act && acc_w, dn && !acc_w, dn && acc_w, res, act};
    endfunction

    always @(negedge clk) begin
        check("model", obs, model_vec());
        check("exclusive", {6'd0, gnt0 & gnt1, done0 & done1}, 8'h00);
    end

    // One lone request; for port 0 the operand is disturbed mid-compare
    task automatic run_one(input bit port, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] r, input string name);
        if (port) begin
            req1 = 1'b1; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b;
        end
        @(negedge clk);
        check({name, "_gnt"}, obs & 8'hF1, port ? 8'b0100_0001 : 8'b1000_0001);
        if (!port) a0 = a ^ 4'hF;
        @(negedge clk);
        check({name, "_done"}, obs, port ? {4'b0101, r, 1'b1} : {4'b1010, r, 1'b1});
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check({name, "_idle"}, obs, {4'b0000, r, 1'b0});
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        bit w;
        // Reset with a request pending
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd9;
        repeat (2) @(negedge clk);
        check("reset_hold", obs, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("single_gnt", obs, 8'b1000_0001);
        @(negedge clk);
        check("single_done", obs, 8'b1010_1001);
        req0 = 1'b0;
        @(negedge clk);
        check("single_idle", obs, 8'b0000_1000);

        // Extremes
        run_one(1'b0, 4'd15, 4'd0,  3'b010, "max_min");
        run_one(1'b1, 4'd0,  4'd15, 3'b100, "min_max");
        run_one(1'b0, 4'd15, 4'd15, 3'b001, "max_max");

        // Reset during CMP aborts the compare
        req0 = 1'b1; a0 = 4'd7; b0 = 4'd2;
        @(negedge clk);
        check("midrst_gnt", obs, 8'b1000_0011);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_zero", obs, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_regnt", obs, 8'b1000_0001);
        @(negedge clk);
        check("midrst_done", obs, 8'b1010_0101);
        req0 = 1'b0;
        @(negedge clk);
        check("midrst_idle", obs, 8'b0000_0100);

        // Tie straight after reset: port 0 first in both modes, then port 1
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; a0 = 4'd5;  b0 = 4'd5;
        req1 = 1'b1; a1 = 4'd12; b1 = 4'd4;
        @(negedge clk);
        check("tie_gnt0", obs, 8'b1000_0001);
        @(negedge clk);
        check("tie_done0", obs, 8'b1010_0011);
        req0 = 1'b0;
        @(negedge clk);
        check("tie_gap", obs, 8'b0000_0010);
        @(negedge clk);
        check("tie_gnt1", obs, 8'b0100_0011);
        @(negedge clk);
        check("tie_done1", obs, 8'b0101_0101);
        req1 = 1'b1;
        req1 = 1'b0;
        @(negedge clk);
        check("tie_idle", obs, 8'b0000_0100);

        // Repeated contention: fixed priority keeps serving port 0, round-robin alternates
        a0 = 4'd2; b0 = 4'd1; a1 = 4'd1; b1 = 4'd2;
        for (int i = 0; i < 3; i++) begin
            w = 1'b0;
`ifdef COMPARE_ARBITER_RR_EN
            w = (i == 1);
`endif
            req0 = 1'b1;
            req1 = 1'b1;
            @(negedge clk);
            check("contend_gnt", obs & 8'hF1, w ? 8'b0100_0001 : 8'b1000_0001);
            @(negedge clk);
            check("contend_done", obs & 8'hF1, w ? 8'b0101_0001 : 8'b1010_0001);
            if (w) req1 = 1'b0;
            else   req0 = 1'b0;
            @(negedge clk);
            check("contend_idle", obs & 8'hF1, 8'h00);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
